// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first.
// A single full-subtractor cell plus a borrow flop does the arithmetic.
// Start/busy/done handshake. The result is copied to D/Bout only when the
// last bit completes, so D/Bout never show partial values.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
);

    // One extra bit so the counter can never wrap before reaching WIDTH-1.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sa_reg, sb_reg, sr_reg, d_reg;
    logic             br_reg, bout_reg;
    logic [CW-1:0]    cnt_reg;

    logic             a0, b0, d_bit, br_next, last_bit;
    logic [WIDTH-1:0] sr_shifted;

    // Full-subtractor cell on the current LSBs and the running borrow.
    assign a0       = sa_reg[0];
    assign b0       = sb_reg[0];
    assign d_bit    = a0 ^ b0 ^ br_reg;
    assign br_next  = (~a0 & b0) | (~(a0 ^ b0) & br_reg);
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    // Result register shifted right with the new difference bit at the MSB.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_sr_shift
            assign sr_shifted[gi] = sr_reg[gi+1];
        end
    endgenerate
    assign sr_shifted[WIDTH-1] = d_bit;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and handshake outputs decoded from the state.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, bit-serial datapath and result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa_reg   <= '0;
            sb_reg   <= '0;
            sr_reg   <= '0;
            br_reg   <= 1'b0;
            cnt_reg  <= '0;
            d_reg    <= '0;
            bout_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sa_reg  <= A;
                        sb_reg  <= B;
                        br_reg  <= Bin;
                        cnt_reg <= '0;
                    end
                end
                SHIFT: begin
                    sa_reg  <= {1'b0, sa_reg[WIDTH-1:1]};
                    sb_reg  <= {1'b0, sb_reg[WIDTH-1:1]};
                    sr_reg  <= sr_shifted;
                    br_reg  <= br_next;
                    cnt_reg <= cnt_reg + CW'(1);
                    // Publish the completed result as the FSM enters DONE.
                    if (last_bit) begin
                        d_reg    <= sr_shifted;
                        bout_reg <= br_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign D    = d_reg;
    assign Bout = bout_reg;

endmodule
